// File: rtl/spi_pkg.sv
// Shared definitions for the LCD SPI window: transfer FSM state encoding,
// memory-mapped base address, register offsets and STATUS bit positions.
// Used by spi_lcd_master and by the pipeline memory stage decode.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } spi_state_t;

   localparam logic [31:0] SPI_BASE_ADDR = 32'h8000_0000;

   localparam logic [3:0] REG_DATA   = 4'h0;
   localparam logic [3:0] REG_CTRL   = 4'h4;
   localparam logic [3:0] REG_STATUS = 4'h8;
   localparam logic [3:0] REG_DC     = 4'hC;

   localparam int unsigned STATUS_BUSY = 0;
   localparam int unsigned STATUS_DONE = 1;

endpackage

// File: rtl/spi_tick_gen.sv
// Divider counter for the SPI master. Counts clk cycles and emits a one-cycle
// tick on the last cycle of a phase of length 'limit'.
// Ports:
//   clk, reset : core clock, synchronous active-high reset
//   clear      : synchronous reload to 0 (phase change or idle)
//   limit      : phase length in clk cycles (>= 1)
//   tick       : high during the last cycle of the current phase
module spi_tick_gen #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [CNT_W-1:0] limit,
   output logic             tick
);

   logic [CNT_W-1:0] count_q;

   assign tick = (count_q == limit - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset || clear || tick) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_lcd_master.sv
// Byte-wide SPI mode-0 master for the LCD panel. Accepts a start pulse with a
// data byte and D/C level from the memory stage, shifts the byte out MSB first
// and reports busy / sticky done status.
// Ports:
//   clk, reset : core clock, synchronous active-high reset
//   start_in   : one-cycle start pulse, accepted only when idle
//   data_in    : byte to send (MSB first)
//   dc_in      : D/C level for this byte
//   busy_out   : transfer in progress
//   done_out   : sticky completion flag, cleared by next accepted start
//   sclk_out, mosi_out, cs_n_out, dc_out : panel pins, all registered
module spi_lcd_master
   import spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_HOLD = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_in,
   input  logic [7:0] data_in,
   input  logic       dc_in,
   output logic       busy_out,
   output logic       done_out,
   output logic       sclk_out,
   output logic       mosi_out,
   output logic       cs_n_out,
   output logic       dc_out
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV * CS_HOLD + 1);

   spi_state_t state_q, state_d;
   logic [7:0] shreg_q, shreg_d;
   logic [2:0] bit_q, bit_d;
   logic       sclk_q, sclk_d;
   logic       mosi_q, mosi_d;
   logic       cs_n_q, cs_n_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       dc_q, dc_d;

   logic [CNT_W-1:0] limit;
   logic             tick;
   logic             phase_chg;

   // HOLD is the only phase longer than one SCLK half-period
   assign limit = (state_q == HOLD) ? CNT_W'(CS_HOLD * CLK_DIV) : CNT_W'(CLK_DIV);

   // Every state change and every SCLK edge starts a new phase; the
   // divider is also held at 0 while idle.
   assign phase_chg = (state_q == IDLE) || (state_d != state_q) || (sclk_d != sclk_q);

   spi_tick_gen #(
      .CNT_W(CNT_W)
   ) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (phase_chg),
      .limit (limit),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         bit_q   <= '0;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dc_q    <= dc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      busy_d  = busy_q;
      done_d  = done_q;
      dc_d    = dc_q;
      case (state_q)
         IDLE: begin
            if (start_in) begin
               shreg_d = data_in;
               dc_d    = dc_in;
               mosi_d  = data_in[7];
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               bit_d   = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (!sclk_q) begin
                  sclk_d = 1'b1;
               end else begin
                  // falling edge: present the next bit; bit counter wrapping
                  // from 7 marks the end of the byte
                  sclk_d  = 1'b0;
                  shreg_d = {shreg_q[6:0], 1'b0};
                  mosi_d  = shreg_q[6];
                  bit_d   = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_d = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (tick) begin
               state_d = IDLE;
               cs_n_d  = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               mosi_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy_out = busy_q;
   assign done_out = done_q;
   assign sclk_out = sclk_q;
   assign mosi_out = mosi_q;
   assign cs_n_out = cs_n_q;
   assign dc_out   = dc_q;

endmodule

// File: tb/tb_spi_lcd_master.sv
// Directed bench for spi_lcd_master. Three instances with different divider
// settings share clk/reset; each is driven and monitored through bit k of
// the vectors below.
module tb_spi_lcd_master;

   logic       clk;
   logic       reset;
   logic [2:0] start;
   logic [2:0] dc_i;
   logic [7:0] data [3];
   logic [2:0] busy, done, sclk, mosi, cs_n, dc_o;

   int n_vec = 0;
   int n_bad = 0;

   spi_lcd_master #(.CLK_DIV(2), .CS_HOLD(1)) dut0 (
      .clk(clk), .reset(reset), .start_in(start[0]), .data_in(data[0]), .dc_in(dc_i[0]),
      .busy_out(busy[0]), .done_out(done[0]), .sclk_out(sclk[0]), .mosi_out(mosi[0]),
      .cs_n_out(cs_n[0]), .dc_out(dc_o[0])
   );

   spi_lcd_master #(.CLK_DIV(1), .CS_HOLD(1)) dut1 (
      .clk(clk), .reset(reset), .start_in(start[1]), .data_in(data[1]), .dc_in(dc_i[1]),
      .busy_out(busy[1]), .done_out(done[1]), .sclk_out(sclk[1]), .mosi_out(mosi[1]),
      .cs_n_out(cs_n[1]), .dc_out(dc_o[1])
   );

   spi_lcd_master #(.CLK_DIV(3), .CS_HOLD(2)) dut2 (
      .clk(clk), .reset(reset), .start_in(start[2]), .data_in(data[2]), .dc_in(dc_i[2]),
      .busy_out(busy[2]), .done_out(done[2]), .sclk_out(sclk[2]), .mosi_out(mosi[2]),
      .cs_n_out(cs_n[2]), .dc_out(dc_o[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; start is presented at the next posedge. With
   // inject set, start+0xFF (and a flipped dc_in) are presented during busy
   // cycles 5 and 35 (0-based) to show they are ignored.
   task automatic xfer(input int k, input logic [7:0] d, input logic dc, input bit inject,
                       output logic [7:0] rx, output int cyc, output int nrise, output int hirun);
      logic prev;
      int   run;
      bit   dcbad;
      start[k] = 1'b1;
      data[k]  = d;
      dc_i[k]  = dc;
      @(negedge clk);
      start[k] = 1'b0;
      chk("acc_busy", busy[k], 1);
      chk("acc_done", done[k], 0);
      chk("acc_csn", cs_n[k], 0);
      chk("acc_dc", dc_o[k], dc);
      cyc = 0; nrise = 0; hirun = 0; run = 0; prev = 1'b0; rx = '0; dcbad = 1'b0;
      while (busy[k] === 1'b1 && cyc < 2000) begin
         cyc++;
         if (dc_o[k] !== dc) dcbad = 1'b1;
         if (sclk[k]) begin
            run++;
            if (run > hirun) hirun = run;
            if (!prev) begin
               rx = {rx[6:0], mosi[k]};
               nrise++;
            end
         end else begin
            run = 0;
         end
         prev = sclk[k];
         start[k] = inject && (cyc == 6 || cyc == 36);
         if (start[k]) begin
            data[k] = 8'hFF;
            dc_i[k] = ~dc;
         end
         @(negedge clk);
      end
      start[k] = 1'b0;
      chk("busy_bounded", (cyc < 2000), 1);
      chk("dc_hold", dcbad, 0);
      chk("end_done", done[k], 1);
      chk("end_csn", cs_n[k], 1);
      chk("end_mosi", mosi[k], 0);
      chk("end_sclk", sclk[k], 0);
   endtask

   task automatic do_xfer(input int k, input logic [7:0] d, input logic dc, input bit inject,
                          input int exp_cyc, input int exp_hi, output int nrise);
      logic [7:0] rx;
      int cyc, hirun;
      xfer(k, d, dc, inject, rx, cyc, nrise, hirun);
      chk("rx_byte", rx, d);
      chk("busy_cycles", cyc, exp_cyc);
      chk("sclk_rises", nrise, 8);
      chk("sclk_high_len", hirun, exp_hi);
   endtask

   initial begin
      int nr, nr2, cnt;
      logic prev;
      reset = 1'b1;
      start = '0;
      dc_i  = '0;
      for (int i = 0; i < 3; i++) data[i] = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_busy", busy[k], 0);
         chk("rst_done", done[k], 0);
         chk("rst_sclk", sclk[k], 0);
         chk("rst_mosi", mosi[k], 0);
         chk("rst_csn", cs_n[k], 1);
         chk("rst_dc", dc_o[k], 0);
      end

      // 1: 0xA5 as data, CLK_DIV=2 -> 36 busy cycles
      do_xfer(0, 8'hA5, 1'b1, 1'b0, 36, 2, nr);

      // 2: starts during busy (incl. last HOLD cycle) are dropped
      @(negedge clk);
      do_xfer(0, 8'h3C, 1'b0, 1'b1, 36, 2, nr);
      cnt = 0;
      repeat (6) begin
         if (busy[0]) cnt++;
         @(negedge clk);
      end
      chk("single_busy", cnt, 0);

      // 3: reset in the 4th SCLK high phase aborts with idle pins, no done
      start[0] = 1'b1; data[0] = 8'h81; dc_i[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      nr = 0; prev = 1'b0; cnt = 0;
      while (nr < 4 && cnt < 200) begin
         if (sclk[0] && !prev) nr++;
         prev = sclk[0];
         if (nr < 4) begin
            cnt++;
            @(negedge clk);
         end
      end
      chk("abort_reach_4th_high", nr, 4);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_csn", cs_n[0], 1);
      chk("abort_sclk", sclk[0], 0);
      chk("abort_mosi", mosi[0], 0);
      chk("abort_busy", busy[0], 0);
      chk("abort_done", done[0], 0);
      nr = 0; prev = sclk[0];
      repeat (60) begin
         @(negedge clk);
         if (sclk[0] && !prev) nr++;
         prev = sclk[0];
      end
      chk("abort_no_sclk", nr, 0);
      chk("abort_done_later", done[0], 0);

      // 4: back-to-back, second start on first idle cycle
      do_xfer(0, 8'h11, 1'b0, 1'b0, 36, 2, nr);
      chk("b2b_gap_dc", dc_o[0], 0);
      chk("b2b_gap_csn", cs_n[0], 1);
      do_xfer(0, 8'h22, 1'b1, 1'b0, 36, 2, nr2);
      chk("b2b_total_rises", nr + nr2, 16);

      // 5: CLK_DIV=1 -> 18 busy cycles, SCLK toggles every cycle
      @(negedge clk);
      do_xfer(1, 8'h00, 1'b0, 1'b0, 18, 1, nr);
      do_xfer(1, 8'hFF, 1'b1, 1'b0, 18, 1, nr);

      // CLK_DIV=3, CS_HOLD=2 -> (1+16+2)*3 = 57 busy cycles
      @(negedge clk);
      do_xfer(2, 8'h5A, 1'b1, 1'b0, 57, 3, nr);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/spi_lcd_master.md
Name: spi_lcd_master

Overview:
Byte-wide SPI master (mode 0, CPOL=0/CPHA=0) for the LCD panel attached to the core's memory-mapped SPI window at 0x80000000. It sits directly downstream of the pipeline memory stage. It consumes that stage's start pulse, data byte and D/C bit, and returns the busy/done status that software polls through the STATUS register. It drives the SCLK, MOSI, CS_N and D/C pins of the panel.

Parameters:
CLK_DIV, 4, number of clk cycles per SCLK half-period; legal range >= 1.
CS_HOLD, 1, CS_N hold time after the last SCLK falling edge, in units of CLK_DIV cycles; legal range >= 1.

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
start_in  input  1  one-cycle start pulse from the memory stage (CTRL write)
data_in  input  8  byte to transmit, MSB first
dc_in  input  1  D/C level to present for this byte (0 = command, 1 = data)
busy_out  output  1  transfer in progress (STATUS bit 0)
done_out  output  1  sticky "last transfer complete" flag (STATUS bit 1)
sclk_out  output  1  SPI clock, idles low
mosi_out  output  1  SPI data out
cs_n_out  output  1  chip select, active low
dc_out  output  1  D/C pin to panel

Behaviour:
- Clock and reset: clk, with synchronous active-high reset named reset.
- Reset values: busy_out=0, done_out=0, sclk_out=0, mosi_out=0, cs_n_out=1, dc_out=0, state=IDLE, all counters 0. A reset mid-transfer aborts immediately; the next edge shows the idle pin levels and no done pulse.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - start_in is accepted only in this state.
  - On the accepting edge the block latches data_in into an 8-bit shift register and latches dc_in into dc_out.
  - Same edge: cs_n_out=0, mosi_out=data_in[7], busy_out=1, done_out=0, next state SETUP.
- SETUP: hold for CLK_DIV cycles with sclk_out low, then go to SHIFT.
- SHIFT: 8 bits, each 2*CLK_DIV cycles long.
  - sclk_out is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - The rising edge is the slave's sample point. mosi_out is stable across it.
  - On each high-to-low transition the register shifts left and mosi_out takes the next bit.
  - After the 8th high phase, sclk_out returns low and the state becomes HOLD.
  - A 3-bit bit counter is used; wrap from 7 ends the phase.
- HOLD: CS_HOLD*CLK_DIV cycles with cs_n_out still low, then IDLE.
  - Same edge as entering IDLE: cs_n_out=1, busy_out=0, done_out=1, mosi_out=0.
- Latency: busy_out is high for exactly (1+16+CS_HOLD)*CLK_DIV cycles. With defaults this is 72 cycles.
- done_out: sticky until the next accepted start or reset.
- start_in while not IDLE, including the final HOLD cycle: ignored and dropped; no queueing. Software must poll busy_out before issuing CTRL.
- data_in and dc_in changes while busy: no effect on the transfer in flight. dc_out keeps its latched value until the next accepted start.
- Divider counter: width $clog2(CLK_DIV*CS_HOLD+1). It reloads to 0 on every phase change and never free-runs in IDLE.
- All outputs are registered; there is no combinational path from inputs to pins.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE/SETUP/SHIFT/HOLD);
  - SPI_BASE_ADDR=0x80000000;
  - register offsets DATA=0x0, CTRL=0x4, STATUS=0x8, DC=0xC;
  - STATUS bit positions BUSY=0, DONE=1.
  The memory stage uses the same package.
- One natural sub-module, spi_tick_gen: the divider counter producing a one-cycle half-period tick, with a synchronous clear on phase change. The shift register and FSM stay in the top.

Test Plan:
1. CLK_DIV=2, CS_HOLD=1, data_in=0xA5, dc_in=1, one start pulse:
   - MOSI sampled at the 8 SCLK rising edges = 1,0,1,0,0,1,0,1;
   - dc_out=1 throughout;
   - busy_out high for exactly 36 cycles;
   - done_out=1 and cs_n_out=1 on the same edge that busy_out falls.
2. Start 0x3C; pulse start_in=1 with data_in=0xFF at cycles 5 and 35 (the last HOLD cycle) of the busy period:
   - both pulses ignored, 0x3C transmitted unchanged;
   - exactly one busy period.
3. Reset asserted at the 4th SCLK high phase of a 0x81 transfer:
   - next edge shows cs_n_out=1, sclk_out=0, mosi_out=0, busy_out=0, done_out=0;
   - no further SCLK edges.
4. Back-to-back transfers: start 0x11 (dc=0), then start 0x22 (dc=1) on the first cycle busy_out=0:
   - done_out clears on the second accepting edge;
   - dc_out switches 0->1 only at that edge;
   - 16 rising edges in total, with a CS_N high gap of at least 1 cycle between the two bytes.
5. CLK_DIV=1, data_in=0x00 then 0xFF:
   - SCLK toggles every cycle;
   - busy_out high 18 cycles per byte;
   - MOSI all-0 then all-1 at the rising edges.
